nurn_recall_engine: RTL and testbench

//  Parametrised, handshaked recall engine for one time-multiplexed neuron per pass.
//  Per neuron:
//   - loads membrane potential and refractory count from status memory;
//   - accumulates weights of spiking axons from a valid/ready stream;
//   - adds bias, applies optional leak, compares against threshold;
//   - writes back potential/refractory count and pulses an output spike to the router.

---
 rtl/nurn_recall_engine_if.sv | 13 +
 rtl/nurn_recall_engine.sv | 207 ++++++++++++++++++++
 tb/tb_nurn_recall_engine.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/nurn_recall_engine_if.sv
// Weight-beat stream between the axon/weight source and the neuron recall engine.
// The source drives valid/data/spike; the engine drives ready.
interface nurn_recall_engine_if #(
  parameter int DSIZE = 16
);
  logic             wt_valid;
  logic [DSIZE-1:0] wt_data;
  logic             wt_spike;
  logic             wt_ready;

  modport master (output wt_valid, output wt_data, output wt_spike, input wt_ready);
  modport slave  (input wt_valid, input wt_data, input wt_spike, output wt_ready);
endinterface

// File: rtl/nurn_recall_engine.sv
// Time-multiplexed neuron recall engine: accumulates spiking-axon weights, adds bias,
// applies an optional leak, fires against threshold and writes back potential/refractory state.
module nurn_recall_engine #(
  parameter int DATA_BIT_WIDTH_INT  = 8,
  parameter int DATA_BIT_WIDTH_FRAC = 8,
  parameter int NUM_AXONS           = 256,
  parameter int AXON_CNT_BIT_WIDTH  = 8,
  parameter int REFRAC_BIT_WIDTH    = 4,
  parameter int LEAK_SHIFT_WIDTH    = 3,
  localparam int DSIZE = DATA_BIT_WIDTH_INT + DATA_BIT_WIDTH_FRAC
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        start_i,
  input  logic [1:0]                  nurnType_i,
  input  logic [LEAK_SHIFT_WIDTH-1:0] leakShift_i,
  input  logic [REFRAC_BIT_WIDTH-1:0] refracPer_i,
  input  logic [DSIZE-1:0]            rstPot_i,
  input  logic [DSIZE-1:0]            th_i,
  input  logic [DSIZE-1:0]            bias_i,
  input  logic [DSIZE-1:0]            membPot_i,
  input  logic [REFRAC_BIT_WIDTH-1:0] refracCnt_i,
  nurn_recall_engine_if.slave         wtBus,
  output logic [DSIZE-1:0]            membPot_o,
  output logic [REFRAC_BIT_WIDTH-1:0] refracCnt_o,
  output logic                        wrEn_o,
  output logic                        outSpike_o,
  output logic                        done_o,
  output logic                        busy_o,
  output logic                        sat_o
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    ACCUM = 3'd2,
    BIAS  = 3'd3,
    LEAK  = 3'd4,
    FIRE  = 3'd5,
    WB    = 3'd6
  } state_t;

  localparam logic [DSIZE-1:0] MAX_VAL = {1'b0, {(DSIZE-1){1'b1}}};
  localparam logic [DSIZE-1:0] MIN_VAL = {1'b1, {(DSIZE-1){1'b0}}};
  localparam logic [AXON_CNT_BIT_WIDTH-1:0] LAST_BEAT = AXON_CNT_BIT_WIDTH'(NUM_AXONS - 1);
  localparam logic [AXON_CNT_BIT_WIDTH-1:0] ONE_BEAT  = {{(AXON_CNT_BIT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [REFRAC_BIT_WIDTH-1:0]   ONE_REFR  = {{(REFRAC_BIT_WIDTH-1){1'b0}}, 1'b1};

  // Result MSB is the clip flag; lower DSIZE bits are the saturated sum.
  function automatic logic [DSIZE:0] satAdd(input logic [DSIZE-1:0] a, input logic [DSIZE-1:0] b);
    logic [DSIZE:0] sum;
    sum = {a[DSIZE-1], a} + {b[DSIZE-1], b};
    if (sum[DSIZE] != sum[DSIZE-1]) begin
      satAdd = {1'b1, (sum[DSIZE] ? MIN_VAL : MAX_VAL)};
    end else begin
      satAdd = {1'b0, sum[DSIZE-1:0]};
    end
  endfunction

  function automatic logic [DSIZE:0] satSub(input logic [DSIZE-1:0] a, input logic [DSIZE-1:0] b);
    logic [DSIZE:0] diff;
    diff = {a[DSIZE-1], a} - {b[DSIZE-1], b};
    if (diff[DSIZE] != diff[DSIZE-1]) begin
      satSub = {1'b1, (diff[DSIZE] ? MIN_VAL : MAX_VAL)};
    end else begin
      satSub = {1'b0, diff[DSIZE-1:0]};
    end
  endfunction

  state_t                      state_r;
  logic [DSIZE-1:0]            acc_r;
  logic [REFRAC_BIT_WIDTH-1:0] refr_r;
  logic [AXON_CNT_BIT_WIDTH-1:0] beatCnt_r;
  logic                        spk_r;
  logic                        ready_r;
  logic [DSIZE-1:0]            membPot_r;
  logic [REFRAC_BIT_WIDTH-1:0] refracCnt_r;
  logic                        wrEn_r;
  logic                        outSpike_r;
  logic                        done_r;
  logic                        busy_r;
  logic                        sat_r;

  logic [DSIZE-1:0] addOperand_s;
  logic [DSIZE:0]   addRes_s;
  logic [DSIZE-1:0] leakAmt_s;
  logic [DSIZE:0]   subRes_s;

  // Shared saturating adder (weight or bias) and leak subtractor.
  always_comb begin
    addOperand_s = '0;
    case (state_r)
      ACCUM:   addOperand_s = wtBus.wt_data;
      BIAS:    addOperand_s = bias_i;
      default: addOperand_s = '0;
    endcase
    addRes_s  = satAdd(acc_r, addOperand_s);
    leakAmt_s = $signed(acc_r) >>> leakShift_i;
    subRes_s  = satSub(acc_r, leakAmt_s);
  end

  // Pass sequencer with all outputs registered.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r     <= IDLE;
      acc_r       <= '0;
      refr_r      <= '0;
      beatCnt_r   <= '0;
      spk_r       <= 1'b0;
      ready_r     <= 1'b0;
      membPot_r   <= '0;
      refracCnt_r <= '0;
      wrEn_r      <= 1'b0;
      outSpike_r  <= 1'b0;
      done_r      <= 1'b0;
      busy_r      <= 1'b0;
      sat_r       <= 1'b0;
    end else begin
      wrEn_r     <= 1'b0;
      done_r     <= 1'b0;
      outSpike_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start_i) begin
            state_r <= LOAD;
            busy_r  <= 1'b1;
          end
        end
        LOAD: begin
          acc_r     <= membPot_i;
          refr_r    <= refracCnt_i;
          beatCnt_r <= '0;
          sat_r     <= 1'b0;
          ready_r   <= 1'b1;
          state_r   <= ACCUM;
        end
        ACCUM: begin
          if (wtBus.wt_valid && ready_r) begin
            if (wtBus.wt_spike) begin
              acc_r <= addRes_s[DSIZE-1:0];
              if (addRes_s[DSIZE]) sat_r <= 1'b1;
            end
            if (beatCnt_r == LAST_BEAT) begin
              beatCnt_r <= '0;
              ready_r   <= 1'b0;
              state_r   <= BIAS;
            end else begin
              beatCnt_r <= beatCnt_r + ONE_BEAT;
            end
          end
        end
        BIAS: begin
          acc_r <= addRes_s[DSIZE-1:0];
          if (addRes_s[DSIZE]) sat_r <= 1'b1;
          state_r <= LEAK;
        end
        LEAK: begin
          if (nurnType_i == 2'd2) begin
            acc_r <= subRes_s[DSIZE-1:0];
            if (subRes_s[DSIZE]) sat_r <= 1'b1;
          end
          state_r <= FIRE;
        end
        FIRE: begin
          spk_r   <= (nurnType_i != 2'd1) && (refr_r == '0) && ($signed(acc_r) >= $signed(th_i));
          state_r <= WB;
        end
        WB: begin
          wrEn_r     <= 1'b1;
          done_r     <= 1'b1;
          outSpike_r <= spk_r;
          busy_r     <= 1'b0;
          state_r    <= IDLE;
          // A refractory neuron still drains its beats but is pinned to the reset potential.
          if (refr_r != '0) begin
            membPot_r   <= rstPot_i;
            refracCnt_r <= refr_r - ONE_REFR;
          end else if (spk_r) begin
            membPot_r   <= rstPot_i;
            refracCnt_r <= refracPer_i;
          end else if (nurnType_i == 2'd1) begin
            membPot_r   <= acc_r[DSIZE-1] ? '0 : acc_r;
            refracCnt_r <= '0;
          end else begin
            membPot_r   <= acc_r;
            refracCnt_r <= '0;
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          ready_r <= 1'b0;
        end
      endcase
    end
  end

  assign wtBus.wt_ready = ready_r;
  assign membPot_o      = membPot_r;
  assign refracCnt_o    = refracCnt_r;
  assign wrEn_o         = wrEn_r;
  assign outSpike_o     = outSpike_r;
  assign done_o         = done_r;
  assign busy_o         = busy_r;
  assign sat_o          = sat_r;

endmodule

// File: tb/tb_nurn_recall_engine.sv
// Directed bench for nurn_recall_engine in Q8.8 with four axons per pass.
module tb_nurn_recall_engine;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  nurnType;
  logic [2:0]  leakShift;
  logic [3:0]  refracPer;
  logic [15:0] rstPot;
  logic [15:0] th;
  logic [15:0] bias;
  logic [15:0] membPotIn;
  logic [3:0]  refracCntIn;
  logic [15:0] membPotOut;
  logic [3:0]  refracCntOut;
  logic        wrEn;
  logic        outSpike;
  logic        done;
  logic        busy;
  logic        sat;

  int checks = 0;
  int errors = 0;

  logic [15:0] wts [4];
  logic        spks [4];
  int          stallBeat;
  int          stallCycles;

  int          resEdges;
  logic        gotDone;
  logic [15:0] resMemb;
  logic [3:0]  resRefr;
  logic        resSpike;
  logic        resSat;
  logic        resWr;
  int          wrPulses;

  nurn_recall_engine_if #(.DSIZE(16)) wtBus ();

  nurn_recall_engine #(
    .DATA_BIT_WIDTH_INT (8),
    .DATA_BIT_WIDTH_FRAC(8),
    .NUM_AXONS          (4),
    .AXON_CNT_BIT_WIDTH (2),
    .REFRAC_BIT_WIDTH   (4),
    .LEAK_SHIFT_WIDTH   (3)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .start_i    (start),
    .nurnType_i (nurnType),
    .leakShift_i(leakShift),
    .refracPer_i(refracPer),
    .rstPot_i   (rstPot),
    .th_i       (th),
    .bias_i     (bias),
    .membPot_i  (membPotIn),
    .refracCnt_i(refracCntIn),
    .wtBus      (wtBus),
    .membPot_o  (membPotOut),
    .refracCnt_o(refracCntOut),
    .wrEn_o     (wrEn),
    .outSpike_o (outSpike),
    .done_o     (done),
    .busy_o     (busy),
    .sat_o      (sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic runPass(input logic [15:0] memb, input logic [3:0] refr);
    int   beat;
    int   stallLeft;
    logic accepted;
    logic stalled;
    membPotIn   = memb;
    refracCntIn = refr;
    start       = 1'b1;
    @(posedge clk);
    #1;
    start     = 1'b0;
    resEdges  = 0;
    beat      = 0;
    stallLeft = stallCycles;
    gotDone   = 1'b0;
    while (!gotDone && resEdges < 60) begin
      if (beat < 4 && !(beat == stallBeat && stallLeft > 0)) begin
        wtBus.wt_valid = 1'b1;
        wtBus.wt_data  = wts[beat];
        wtBus.wt_spike = spks[beat];
      end else begin
        wtBus.wt_valid = 1'b0;
      end
      accepted = wtBus.wt_valid && wtBus.wt_ready;
      stalled  = !wtBus.wt_valid && wtBus.wt_ready && (beat < 4);
      @(posedge clk);
      resEdges++;
      if (accepted) beat++;
      if (stalled) stallLeft--;
      #1;
      if (done) begin
        gotDone  = 1'b1;
        resMemb  = membPotOut;
        resRefr  = refracCntOut;
        resSpike = outSpike;
        resSat   = sat;
        resWr    = wrEn;
      end
    end
    wtBus.wt_valid = 1'b0;
  endtask

  task automatic checkPass(input string tag, input int expEdges, input logic [15:0] expMemb,
                           input logic [3:0] expRefr, input logic expSpike, input logic expSat);
    check({tag, "_done"}, 32'(gotDone), 32'd1);
    check({tag, "_latency"}, 32'(resEdges), 32'(expEdges));
    check({tag, "_wrEn"}, 32'(resWr), 32'd1);
    check({tag, "_membPot"}, 32'(resMemb), 32'(expMemb));
    check({tag, "_refracCnt"}, 32'(resRefr), 32'(expRefr));
    check({tag, "_spike"}, 32'(resSpike), 32'(expSpike));
    check({tag, "_sat"}, 32'(resSat), 32'(expSat));
    @(posedge clk);
    #1;
    check({tag, "_pulseEnd"}, {29'd0, wrEn, done, outSpike}, 32'd0);
    check({tag, "_idle"}, 32'(busy), 32'd0);
    check({tag, "_hold"}, 32'(membPotOut), 32'(expMemb));
  endtask

  task automatic setWeights(input logic [15:0] w, input logic [3:0] mask);
    for (int i = 0; i < 4; i++) begin
      wts[i]  = w;
      spks[i] = mask[i];
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    nurnType = 2'd0;
    leakShift = 3'd0;
    refracPer = 4'd5;
    rstPot = 16'h0020;
    th = 16'h0500;
    bias = 16'h0000;
    membPotIn = 16'h0000;
    refracCntIn = 4'd0;
    wtBus.wt_valid = 1'b0;
    wtBus.wt_data = 16'h0000;
    wtBus.wt_spike = 1'b0;
    stallBeat = -1;
    stallCycles = 0;
    wrPulses = 0;
    setWeights(16'h0000, 4'b0000);
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {24'd0, wrEn, outSpike, done, busy, sat, wtBus.wt_ready, 2'd0}, 32'd0);
    check("reset_membPot", 32'(membPotOut), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // I&F fires exactly at threshold.
    setWeights(16'h0100, 4'b1111);
    runPass(16'h0100, 4'd0);
    checkPass("if_fire", 9, 16'h0020, 4'd5, 1'b1, 1'b0);

    // I&F below threshold: spike gating on alternate axons, bias added, no leak for type 0.
    leakShift = 3'd1;
    bias = 16'h0080;
    setWeights(16'h0100, 4'b0101);
    runPass(16'h0100, 4'd0);
    checkPass("if_nofire", 9, 16'h0380, 4'd0, 1'b0, 1'b0);

    // Refractory neuron is pinned to reset potential and counts down.
    bias = 16'h0000;
    th = 16'h0100;
    setWeights(16'h1000, 4'b1111);
    runPass(16'h0000, 4'd3);
    checkPass("refrac", 9, 16'h0020, 4'd2, 1'b0, 1'b0);

    // Positive saturation through a ReLU neuron.
    nurnType = 2'd1;
    th = 16'h0000;
    setWeights(16'h7FFF, 4'b1111);
    runPass(16'h7F00, 4'd0);
    checkPass("sat_pos", 9, 16'h7FFF, 4'd0, 1'b0, 1'b1);

    // Negative saturation through an I&F neuron.
    nurnType = 2'd0;
    setWeights(16'h8000, 4'b1111);
    runPass(16'h8100, 4'd0);
    checkPass("sat_neg", 9, 16'h8000, 4'd0, 1'b0, 1'b1);

    // LIF halves the potential; also shows the sticky flag cleared at the next load.
    nurnType = 2'd2;
    leakShift = 3'd1;
    th = 16'h7FFF;
    setWeights(16'h0100, 4'b0000);
    runPass(16'h0800, 4'd0);
    checkPass("lif", 9, 16'h0400, 4'd0, 1'b0, 1'b0);

    // ReLU clamps a negative result to zero and never spikes.
    nurnType = 2'd1;
    leakShift = 3'd0;
    th = 16'h0000;
    setWeights(16'hFE00, 4'b1111);
    runPass(16'h0000, 4'd0);
    checkPass("relu", 9, 16'h0000, 4'd0, 1'b0, 1'b0);

    // Three stalled cycles on beat 1 shift completion by three edges.
    nurnType = 2'd0;
    th = 16'h0500;
    stallBeat = 1;
    stallCycles = 3;
    setWeights(16'h0100, 4'b1111);
    runPass(16'h0100, 4'd0);
    checkPass("stall", 12, 16'h0020, 4'd5, 1'b0 | 1'b1, 1'b0);
    stallBeat = -1;
    stallCycles = 0;

    // Reset in the middle of accumulation aborts the pass with no write-back.
    membPotIn = 16'h0100;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wtBus.wt_valid = 1'b1;
    wtBus.wt_data = 16'h0100;
    wtBus.wt_spike = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("mid_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("abort_state", {29'd0, busy, wtBus.wt_ready, wrEn}, 32'd0);
    check("abort_membPot", 32'(membPotOut), 32'd0);
    wtBus.wt_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (wrEn || done) wrPulses++;
    end
    check("abort_noWrEn", 32'(wrPulses), 32'd0);

    runPass(16'h0100, 4'd0);
    checkPass("after_reset", 9, 16'h0020, 4'd5, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
